// File: rtl/ifetch_issue.sv
// rtl/ifetch_issue.sv - fetch PC issue, 2-cycle BRAM read tracking and 3-entry response queue

// 3-entry first-word-fall-through queue holding {instruction, pc} pairs.
module ifetch_resp_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [3];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [1:0]   count_q;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count_q <= 2'd0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = (count_q != 2'd0) ? mem[rd_ptr] : '0;
  assign count     = count_q;

endmodule

// Owns the fetch PC and keeps every issued read accounted for until decode takes it.
module ifetch_issue #(
  parameter int                       PC_WIDTH   = 32,
  parameter int                       INST_WIDTH = 32,
  parameter int                       PC_STEP    = 4,
  parameter logic [PC_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic                  imem_en_o,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_WIDTH-1:0]   pc_o
);

  localparam int PAIR_W = INST_WIDTH + PC_WIDTH;

  logic [PC_WIDTH-1:0] pc_q;
  logic                v1;
  logic [PC_WIDTH-1:0] pc1;
  logic                v2;
  logic [PC_WIDTH-1:0] pc2;

  logic [1:0]          fifo_count;
  logic [PAIR_W-1:0]   fifo_head;
  logic                issue;
  logic                push;
  logic                pop;
  logic [2:0]          credits_used;

  // Reads in flight plus queued entries may never exceed 3, counting the slot freed by this cycle's pop.
  assign credits_used = {2'b00, v1} + {2'b00, v2} + {1'b0, fifo_count} - {2'b00, pop};
  assign issue        = ~rst & ~redirect_i & (credits_used <= 3'd2);
  assign inst_valid_o = ~rst & ~redirect_i & (fifo_count != 2'd0);
  assign pop          = inst_valid_o & inst_ready_i;
  assign push         = v2 & ~redirect_i;

  assign imem_en_o    = issue;
  assign imem_addr_o  = pc_q;

  // PC advance and the two-stage read-latency tracker; redirect kills everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      v1   <= 1'b0;
      pc1  <= '0;
      v2   <= 1'b0;
      pc2  <= '0;
    end else if (redirect_i) begin
      pc_q <= redirect_pc_i;
      v1   <= 1'b0;
      v2   <= 1'b0;
    end else begin
      if (issue) pc_q <= pc_q + PC_WIDTH'(PC_STEP);
      v1  <= issue;
      pc1 <= pc_q;
      v2  <= v1;
      pc2 <= pc1;
    end
  end

  ifetch_resp_fifo #(
    .W (PAIR_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (push),
    .push_data ({imem_rdata_i, pc2}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign inst_o = fifo_head[PAIR_W-1:PC_WIDTH];
  assign pc_o   = fifo_head[PC_WIDTH-1:0];

endmodule

// File: tb/tb_ifetch_issue.sv
// tb/tb_ifetch_issue.sv - directed vector bench for ifetch_issue
module tb_ifetch_issue;

  localparam logic [31:0] MAGIC = 32'hC0DE_0000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, redirect_i, imem_en_o, inst_valid_o, inst_ready_i;
  logic [31:0] redirect_pc_i, imem_addr_o, imem_rdata_i, inst_o, pc_o;
  logic [31:0] bram_d1;

  // 8-bit PC instance for wrap checks
  logic        w_rst, w_redirect, w_en, w_valid, w_ready;
  logic [7:0]  w_rpc, w_addr, w_pc, bram_wd1;
  logic [31:0] w_rdata, w_inst;

  ifetch_issue dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o)
  );

  ifetch_issue #(.PC_WIDTH(8)) dut_w (
    .clk           (clk),
    .rst           (w_rst),
    .redirect_i    (w_redirect),
    .redirect_pc_i (w_rpc),
    .imem_en_o     (w_en),
    .imem_addr_o   (w_addr),
    .imem_rdata_i  (w_rdata),
    .inst_valid_o  (w_valid),
    .inst_ready_i  (w_ready),
    .inst_o        (w_inst),
    .pc_o          (w_pc)
  );

  // BRAM models: 2-cycle latency, data = address ^ MAGIC
  always @(posedge clk) begin
    bram_d1      <= imem_addr_o;
    imem_rdata_i <= bram_d1 ^ MAGIC;
    bram_wd1     <= w_addr;
    w_rdata      <= {24'h0, bram_wd1} ^ MAGIC;
  end

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_pc;
  int beats;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        val;
    logic        chk;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic d, input logic [31:0] rp, input logic y,
                              input logic e, input logic [31:0] a, input logic v, input logic c,
                              input logic [31:0] p);
    vec_t t;
    t.rst = r; t.redir = d; t.rpc = rp; t.rdy = y;
    t.en = e; t.addr = a; t.val = v; t.chk = c; t.pc = p;
    return t;
  endfunction

  vec_t tbl[21];

  task automatic stream_cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    inst_ready_i  = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    @(negedge clk);
    if (redir) begin
      check("redir_valid", {31'h0, inst_valid_o}, 32'h0);
      check("redir_en", {31'h0, imem_en_o}, 32'h0);
    end else if (inst_valid_o && rdy) begin
      check("stream_pc", pc_o, exp_pc);
      check("stream_inst", inst_o, exp_pc ^ MAGIC);
      exp_pc = exp_pc + 32'h4;
      beats++;
    end
    @(posedge clk); #1;
    if (redir) exp_pc = rpc;
  endtask

  logic [7:0] wexp [3];
  int wb;

  initial begin
    //           rst redir rpc        rdy  en  addr        val chk pc
    tbl[0]  = mk(H, L, 32'h0,   H,   L, 32'h0,   L, H, 32'h0);
    tbl[1]  = mk(L, L, 32'h0,   H,   H, 32'h0,   L, H, 32'h0);
    tbl[2]  = mk(L, L, 32'h0,   H,   H, 32'h4,   L, H, 32'h0);
    tbl[3]  = mk(L, L, 32'h0,   H,   H, 32'h8,   L, H, 32'h0);
    tbl[4]  = mk(L, L, 32'h0,   H,   H, 32'hC,   H, H, 32'h0);
    tbl[5]  = mk(L, L, 32'h0,   L,   L, 32'h10,  H, H, 32'h4);
    tbl[6]  = mk(L, H, 32'h100, L,   L, 32'h10,  L, L, 32'h0);
    tbl[7]  = mk(L, L, 32'h0,   H,   H, 32'h100, L, H, 32'h0);
    tbl[8]  = mk(L, L, 32'h0,   H,   H, 32'h104, L, H, 32'h0);
    tbl[9]  = mk(L, L, 32'h0,   H,   H, 32'h108, L, H, 32'h0);
    tbl[10] = mk(L, L, 32'h0,   H,   H, 32'h10C, H, H, 32'h100);
    tbl[11] = mk(L, L, 32'h0,   L,   L, 32'h110, H, H, 32'h104);
    tbl[12] = mk(L, L, 32'h0,   L,   L, 32'h110, H, H, 32'h104);
    tbl[13] = mk(L, L, 32'h0,   L,   L, 32'h110, H, H, 32'h104);
    tbl[14] = mk(H, L, 32'h0,   H,   L, 32'h110, L, L, 32'h0);
    tbl[15] = mk(H, L, 32'h0,   H,   L, 32'h0,   L, H, 32'h0);
    tbl[16] = mk(L, L, 32'h0,   H,   H, 32'h0,   L, H, 32'h0);
    tbl[17] = mk(L, L, 32'h0,   H,   H, 32'h4,   L, H, 32'h0);
    tbl[18] = mk(L, L, 32'h0,   H,   H, 32'h8,   L, H, 32'h0);
    tbl[19] = mk(L, L, 32'h0,   H,   H, 32'hC,   H, H, 32'h0);
    tbl[20] = mk(L, L, 32'h0,   H,   H, 32'h10,  H, H, 32'h4);

    wexp[0] = 8'hFC; wexp[1] = 8'h00; wexp[2] = 8'h04;

    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; inst_ready_i = 1'b1;
    w_rst = 1'b1; w_redirect = 1'b0; w_rpc = 8'h0; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset, start-up latency, stall, redirect during stall, reset with full queue, restart
    for (int i = 0; i < 21; i++) begin
      rst           = tbl[i].rst;
      redirect_i    = tbl[i].redir;
      redirect_pc_i = tbl[i].rpc;
      inst_ready_i  = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_en", i), {31'h0, imem_en_o}, {31'h0, tbl[i].en});
      check($sformatf("v%0d_addr", i), imem_addr_o, tbl[i].addr);
      check($sformatf("v%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, tbl[i].val});
      if (tbl[i].chk) begin
        check($sformatf("v%0d_pc", i), pc_o, tbl[i].pc);
        check($sformatf("v%0d_inst", i), inst_o, tbl[i].val ? (tbl[i].pc ^ MAGIC) : 32'h0);
      end
      @(posedge clk); #1;
    end

    // Steady stream, then 6-cycle stall: head held, no issue, no drop/dup on resume
    exp_pc = 32'h8;
    beats = 0;
    repeat (4) stream_cycle(H, L, 32'h0);
    check("pre_stall_beats", beats, 4);
    inst_ready_i = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", s), {31'h0, inst_valid_o}, 32'h1);
      check($sformatf("stall%0d_pc", s), pc_o, exp_pc);
      check($sformatf("stall%0d_en", s), {31'h0, imem_en_o}, 32'h0);
      @(posedge clk); #1;
    end
    beats = 0;
    repeat (8) stream_cycle(H, L, 32'h0);
    check("resume_beats", beats, 8);

    // Redirect while push+pop would occur, immediately followed by a second redirect
    stream_cycle(H, H, 32'h200);
    stream_cycle(H, H, 32'h300);
    beats = 0;
    repeat (6) stream_cycle(H, L, 32'h0);
    check("redirect_beats", beats, 3);
    check("redirect_next_pc", exp_pc, 32'h30C);

    // 8-bit PC wrap after redirect to 0xFC
    w_rst = 1'b0; w_redirect = 1'b1; w_rpc = 8'hFC;
    @(negedge clk);
    check("wrap_redir_valid", {31'h0, w_valid}, 32'h0);
    @(posedge clk); #1;
    w_redirect = 1'b0;
    wb = 0;
    repeat (6) begin
      @(negedge clk);
      if (w_valid && wb < 3) begin
        check($sformatf("wrap_pc%0d", wb), {24'h0, w_pc}, {24'h0, wexp[wb]});
        check($sformatf("wrap_inst%0d", wb), w_inst, {24'h0, wexp[wb]} ^ MAGIC);
        wb++;
      end
      @(posedge clk); #1;
    end
    check("wrap_beats", wb, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
